unidade_de_busca: RTL and testbench

UNIDADE_DE_BUSCA -- requirements
Module: unidade_de_busca

---
 rtl/unidade_de_busca_pkg.sv | 29 ++
 rtl/unidade_de_busca_contador.sv | 36 +++
 rtl/unidade_de_busca.sv | 136 +++++++++++++
 tb/tb_unidade_de_busca.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/unidade_de_busca_pkg.sv
// Shared definitions for the fetch unit: opcode constants, where the opcode
// field sits in an instruction word, the fetch FSM state type and the
// program-counter next-address selector.
package pacote_processador;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;

  localparam logic [4:0] OP_JUMP = 5'd16;
  localparam logic [4:0] OP_HALT = 5'd18;

  typedef enum logic [1:0] {
    INICIO   = 2'd0,
    BUSCANDO = 2'd1,
    PARADO   = 2'd2
  } estado_t;

  typedef enum logic [1:0] {
    PC_MANTER      = 2'd0,
    PC_INCREMENTAR = 2'd1,
    PC_SALTAR      = 2'd2,
    PC_DESVIAR     = 2'd3
  } pc_sel_t;

  function automatic logic [4:0] opcode_de(input logic [31:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/unidade_de_busca_contador.sv
// Program counter register with its next-address mux. The fetch FSM picks
// the source; this block only applies it.
module contador_de_programa
  import pacote_processador::*;
#(
  parameter logic [31:0] ENDERECO_INICIAL = 32'd1
) (
  input  logic        clock,
  input  logic        reset,
  input  pc_sel_t     sel,
  input  logic [31:0] alvo_salto,
  input  logic [31:0] alvo_desvio,
  output logic [31:0] pc
);

  logic [31:0] pc_prox;

  // Next-address selection; increment wraps naturally at 32 bits.
  always_comb begin
    pc_prox = pc;
    case (sel)
      PC_MANTER:      pc_prox = pc;
      PC_INCREMENTAR: pc_prox = pc + 32'd1;
      PC_SALTAR:      pc_prox = alvo_salto;
      PC_DESVIAR:     pc_prox = alvo_desvio;
      default:        pc_prox = pc;
    endcase
  end

  // PC register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) pc <= ENDERECO_INICIAL;
    else       pc <= pc_prox;
  end

endmodule

// File: rtl/unidade_de_busca.sv
// Instruction fetch unit: drives the word address to instruction memory,
// registers the returned word for decode, follows direct jumps, stops on halt
// and accepts redirects from execute.
// Optional macro BUSCA_CONTADORES_EN adds fetch and stall event counters.
//
// state    | meaning
// INICIO   | first cycle after reset, memory settling; PC held, nothing issued
// BUSCANDO | fetching one word per cycle unless stalled
// PARADO   | halt retired; PC frozen until a redirect or reset
module unidade_de_busca
  import pacote_processador::*;
#(
  parameter logic [31:0] ENDERECO_INICIAL = 32'd1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] endereco,
  input  logic [31:0] instrucao,
  input  logic        parar,
  input  logic        desvio_valido,
  input  logic [31:0] desvio_alvo,
  output logic [31:0] instrucao_saida,
  output logic [31:0] pc_saida,
  output logic        valido,
  output logic        parado
`ifdef BUSCA_CONTADORES_EN
  ,
  output logic [31:0] total_buscas,
  output logic [31:0] total_paradas
`endif
);

  estado_t     estado, estado_prox;
  pc_sel_t     pc_sel;
  logic        carregar;
  logic        anular;
  logic [31:0] pc;
  logic [4:0]  opcode;
  logic [31:0] alvo_salto;

  assign opcode     = opcode_de(instrucao);
  assign alvo_salto = {5'd0, instrucao[26:0]};
  assign endereco   = pc;

  contador_de_programa #(
    .ENDERECO_INICIAL(ENDERECO_INICIAL)
  ) u_pc (
    .clock      (clock),
    .reset      (reset),
    .sel        (pc_sel),
    .alvo_salto (alvo_salto),
    .alvo_desvio(desvio_alvo),
    .pc         (pc)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= INICIO;
    else       estado <= estado_prox;
  end

  // Next state: redirect always lands in BUSCANDO; a stall freezes the state.
  always_comb begin
    estado_prox = estado;
    if (desvio_valido) begin
      estado_prox = BUSCANDO;
    end else begin
      case (estado)
        INICIO:   estado_prox = BUSCANDO;
        BUSCANDO: if (!parar && opcode == OP_HALT) estado_prox = PARADO;
        PARADO:   estado_prox = PARADO;
        default:  estado_prox = INICIO;
      endcase
    end
  end

  // Control outputs: PC source, output-register load and squash.
  always_comb begin
    pc_sel   = PC_MANTER;
    carregar = 1'b0;
    anular   = 1'b0;
    if (desvio_valido) begin
      pc_sel = PC_DESVIAR;
      anular = 1'b1;
    end else begin
      case (estado)
        BUSCANDO: begin
          if (!parar) begin
            carregar = 1'b1;
            if (opcode == OP_JUMP)      pc_sel = PC_SALTAR;
            else if (opcode == OP_HALT) pc_sel = PC_MANTER;
            else                        pc_sel = PC_INCREMENTAR;
          end
        end
        PARADO:  anular = 1'b1;
        default: ;
      endcase
    end
  end

  // Decode-facing registers; the word and its address only change on a load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instrucao_saida <= '0;
      pc_saida        <= '0;
      valido          <= 1'b0;
    end else if (carregar) begin
      instrucao_saida <= instrucao;
      pc_saida        <= pc;
      valido          <= 1'b1;
    end else if (anular) begin
      valido          <= 1'b0;
    end
  end

  // Halt flag rises one cycle after entering PARADO, so the halt word itself
  // is delivered with valido=1 before parado is reported.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) parado <= 1'b0;
    else       parado <= (estado == PARADO) && !desvio_valido;
  end

`ifdef BUSCA_CONTADORES_EN
  // Event counters, free-running modulo 2^32.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      total_buscas  <= '0;
      total_paradas <= '0;
    end else begin
      if (carregar)                      total_buscas  <= total_buscas + 32'd1;
      if (estado == BUSCANDO && parar)   total_paradas <= total_paradas + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_unidade_de_busca.sv
// Directed bench for unidade_de_busca: expected outputs are queued before
// each clock and popped and compared #1 after the edge.
module tb_unidade_de_busca;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] endereco;
  logic [31:0] instrucao;
  logic        parar;
  logic        desvio_valido;
  logic [31:0] desvio_alvo;
  logic [31:0] instrucao_saida;
  logic [31:0] pc_saida;
  logic        valido;
  logic        parado;
`ifdef BUSCA_CONTADORES_EN
  logic [31:0] total_buscas;
  logic [31:0] total_paradas;
`endif

  logic [31:0] mem [0:127];
  assign instrucao = mem[endereco[6:0]];

  always #5 clock = ~clock;

  unidade_de_busca dut (
    .clock          (clock),
    .reset          (reset),
    .endereco       (endereco),
    .instrucao      (instrucao),
    .parar          (parar),
    .desvio_valido  (desvio_valido),
    .desvio_alvo    (desvio_alvo),
    .instrucao_saida(instrucao_saida),
    .pc_saida       (pc_saida),
    .valido         (valido),
    .parado         (parado)
`ifdef BUSCA_CONTADORES_EN
    ,
    .total_buscas   (total_buscas),
    .total_paradas  (total_paradas)
`endif
  );

  typedef struct {
    string       tag;
    logic [31:0] endereco;
    logic        valido;
    logic        parado;
    logic        chk;
    logic [31:0] pc_saida;
    logic [31:0] instr;
  } esperado_t;

  esperado_t fila[$];
  int checks = 0;
  int errors = 0;

  task automatic esperar(input string tag, input logic [31:0] e, input logic v,
                         input logic p, input logic chk, input logic [31:0] pcs,
                         input logic [31:0] ins);
    esperado_t x;
    x.tag = tag; x.endereco = e; x.valido = v; x.parado = p;
    x.chk = chk; x.pc_saida = pcs; x.instr = ins;
    fila.push_back(x);
  endtask

  task automatic verificar();
    esperado_t x;
    if (fila.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_vazio observed=0 expected>0");
      return;
    end
    x = fila.pop_front();
    checks++;
    assert (endereco === x.endereco) else begin
      errors++;
      $error("FAIL %s endereco observed=%h expected=%h", x.tag, endereco, x.endereco);
    end
    checks++;
    assert (valido === x.valido) else begin
      errors++;
      $error("FAIL %s valido observed=%b expected=%b", x.tag, valido, x.valido);
    end
    checks++;
    assert (parado === x.parado) else begin
      errors++;
      $error("FAIL %s parado observed=%b expected=%b", x.tag, parado, x.parado);
    end
    if (x.chk) begin
      checks++;
      assert (pc_saida === x.pc_saida) else begin
        errors++;
        $error("FAIL %s pc_saida observed=%h expected=%h", x.tag, pc_saida, x.pc_saida);
      end
      checks++;
      assert (instrucao_saida === x.instr) else begin
        errors++;
        $error("FAIL %s instrucao_saida observed=%h expected=%h", x.tag, instrucao_saida, x.instr);
      end
    end
  endtask

  task automatic passo(input string tag, input logic [31:0] e, input logic v,
                       input logic p, input logic chk, input logic [31:0] pcs,
                       input logic [31:0] ins);
    esperar(tag, e, v, p, chk, pcs, ins);
    @(posedge clock);
    #1;
    verificar();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] halt_w;
    logic [31:0] jump_w;
    halt_w = {5'd18, 27'h5};
    jump_w = {5'd16, 27'd76};
    for (int i = 0; i < 128; i++) mem[i] = 32'h0010_0000 + i;

    reset = 1'b1; parar = 1'b0; desvio_valido = 1'b0; desvio_alvo = '0;
    repeat (2) @(posedge clock);
    #1;
    esperar("reset", 32'd1, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    verificar();
    reset = 1'b0;

    passo("inicio", 32'd1, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    passo("busca1", 32'd2, 1'b1, 1'b0, 1'b1, 32'd1, mem[1]);
    passo("busca2", 32'd3, 1'b1, 1'b0, 1'b1, 32'd2, mem[2]);
    passo("busca3", 32'd4, 1'b1, 1'b0, 1'b1, 32'd3, mem[3]);
    passo("busca4", 32'd5, 1'b1, 1'b0, 1'b1, 32'd4, mem[4]);

    parar = 1'b1;
    for (int i = 0; i < 3; i++) passo("parar", 32'd5, 1'b1, 1'b0, 1'b1, 32'd4, mem[4]);
    parar = 1'b0;
    passo("retoma", 32'd6, 1'b1, 1'b0, 1'b1, 32'd5, mem[5]);

    parar = 1'b1; desvio_valido = 1'b1; desvio_alvo = 32'd25;
    passo("desvio_com_parar", 32'd25, 1'b0, 1'b0, 1'b0, '0, '0);
    parar = 1'b0; desvio_valido = 1'b0;
    passo("pos_desvio", 32'd26, 1'b1, 1'b0, 1'b1, 32'd25, mem[25]);

    mem[86] = halt_w;
    desvio_valido = 1'b1; desvio_alvo = 32'd86;
    passo("desvio_86", 32'd86, 1'b0, 1'b0, 1'b0, '0, '0);
    desvio_valido = 1'b0;
    passo("halt", 32'd86, 1'b1, 1'b0, 1'b1, 32'd86, halt_w);
    passo("parado1", 32'd86, 1'b0, 1'b1, 1'b0, '0, '0);
    parar = 1'b1;
    passo("parado2", 32'd86, 1'b0, 1'b1, 1'b0, '0, '0);
    parar = 1'b0;
    desvio_valido = 1'b1; desvio_alvo = 32'd2;
    passo("redir_parado", 32'd2, 1'b0, 1'b0, 1'b0, '0, '0);
    desvio_valido = 1'b0;
    passo("pos_parado", 32'd3, 1'b1, 1'b0, 1'b1, 32'd2, mem[2]);

    desvio_valido = 1'b1; desvio_alvo = 32'hFFFF_FFFF;
    passo("desvio_max", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, '0, '0);
    desvio_valido = 1'b0;
    passo("wrap", 32'd0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, mem[127]);
    passo("pos_wrap", 32'd1, 1'b1, 1'b0, 1'b1, 32'd0, mem[0]);

    desvio_valido = 1'b1; desvio_alvo = 32'd86;
    passo("desvio_86b", 32'd86, 1'b0, 1'b0, 1'b0, '0, '0);
    desvio_valido = 1'b0;
    passo("halt_b", 32'd86, 1'b1, 1'b0, 1'b1, 32'd86, halt_w);
    passo("parado_b", 32'd86, 1'b0, 1'b1, 1'b0, '0, '0);

    #3;
    reset = 1'b1;
    esperar("reset_async", 32'd1, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    #1;
    verificar();

    mem[1] = jump_w;
    @(posedge clock);
    #1;
    reset = 1'b0;
    passo("inicio2", 32'd1, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    passo("jump", 32'd76, 1'b1, 1'b0, 1'b1, 32'd1, jump_w);
    passo("pos_jump", 32'd77, 1'b1, 1'b0, 1'b1, 32'd76, mem[76]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
